uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. It is the consumer of the line produced by the UART transmitter: 1 start bit, 8 data bits LSB-first, an optional parity bit, and 1 stop bit.
- Samples `rx` using a 16x-baud enable tick from the shared baud generator.
- Presents each received byte with a one-cycle valid pulse and error flags to the downstream logic (FIFO or register interface).

Parameters:
- OVERSAMPLE, 16, number of `tick` pulses per bit period; must be even and ≥ 8.
- SYNC_STAGES, 2, number of flip-flop stages that synchronise `rx` into `clk`.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- tick  in  1  oversample enable, one `clk` wide, OVERSAMPLE pulses per bit.
- rx  in  1  asynchronous serial input; idle level is high.
- pen  in  1  parity enable; sampled at start detection.
- peven  in  1  1 = even parity (parity bit = XOR of data), 0 = odd (parity bit = ~XOR); sampled at start detection.
- dout  out  8  received byte.
- valid  out  1  one-cycle pulse: `dout`, `perr` and `ferr` are valid.
- perr  out  1  parity mismatch on this byte; meaningful only while `valid`.
- ferr  out  1  stop bit read as 0; meaningful only while `valid`.
- busy  out  1  high from start detection until the frame completes.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values:
  - `dout`=0, `valid`=0, `perr`=0, `ferr`=0, `busy`=0.
  - State = IDLE, tick counter = 0, bit counter = 0.
  - All synchroniser flops = 1.
- Reset mid-frame abandons the frame; no `valid` is produced.
- `rx` passes through SYNC_STAGES flops before it is used. Call the result `rxs`.
- State IDLE:
  - `busy`=0.
  - When `rxs`==0, go to START, clear the tick counter, latch `pen`/`peven`, and set `busy`=1.
- State START:
  - Count ticks. At tick count OVERSAMPLE/2-1 (mid start bit), sample `rxs`.
  - If `rxs`==1 it is a false start: go to IDLE with no output.
  - Otherwise clear the tick counter and go to DATA.
- State DATA:
  - Sample on every OVERSAMPLE-th tick (the mid-point of each bit).
  - Shift LSB-first into the shift register.
  - After 8 bits, go to PARITY if the latched `pen`==1, else go to STOP.
- State PARITY:
  - Sample at mid-bit.
  - `perr_next` = sample != (XOR(data) ^ ~peven_latched).
- State STOP:
  - Sample at mid-bit.
  - On the clock after the sample:
    - `dout` ← shift register.
    - `valid`=1 for exactly one `clk`.
    - `perr` ← `perr_next` (0 if parity disabled).
    - `ferr` ← ~sample.
    - `busy`=0.
  - If the sample was 1, go to IDLE. If it was 0 (break/framing error), go to WAIT_HIGH.
- State WAIT_HIGH:
  - Stays here until `rxs`==1, then goes to IDLE. This prevents re-triggering on a held-low line.
- Timing:
  - Latency: `valid` rises 1 `clk` after the mid-stop-bit tick, i.e. about 0.5 bit before the stop bit ends. Back-to-back frames therefore work.
  - `tick` is honoured only when it is high. The counters hold when `tick`==0.
  - `perr`/`ferr` are cleared when `valid` deasserts.
  - Tick counter width is clog2(OVERSAMPLE) and wraps to 0 at OVERSAMPLE-1.
  - The bit counter is 3 bits.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of `rxs` at tick counts mid-1, mid and mid+1. Decision timing moves 1 tick later; the `valid` position shifts by the same amount.
- Undefined: a single sample at mid-bit, as specified above.

Decomposition:
- Package uart_pkg holds:
  - State encodings: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - DATA_BITS=8.
  - Default OVERSAMPLE=16.
  - Parity helper function `parity_bit(data, even)`, shared with the transmitter.
- Sub-module uart_rx_sync: parameterised SYNC_STAGES synchroniser, with reset value 1, producing `rxs`.

Test Plan:
- Bench setup for all scenarios: OVERSAMPLE=16, `tick` every 4 `clk`. Scenarios:
  - `pen`=0, frame for 0xA5 with stop=1 → exactly one `valid` pulse, `dout`=0xA5, `perr`=0, `ferr`=0, `busy` low afterwards.
  - `pen`=1, `peven`=1, byte 0x07 (XOR=1), parity bit 1 → `perr`=0. Repeat with parity bit 0 → `perr`=1. With `peven`=0 and parity bit 0 → `perr`=0.
  - `rx` low for 5 ticks then high (glitch shorter than half a bit) → no `valid`, state returns to IDLE, `busy` pulses then clears.
  - Frame 0x00 with stop bit 0, then line held low for 3 bits → `valid`=1 with `ferr`=1 and `dout`=0x00. No further `valid` until `rx` returns high and a new start bit arrives.
  - Two back-to-back frames 0x55 then 0xC3, next start edge immediately after the stop bit → two `valid` pulses, in that order, with the correct data.
  - `rst`=1 asserted during data bit 4 of a frame → all outputs 0 on the next `clk`, no `valid`. The next complete frame, 0x3C, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive/transmit pair: FSM state encoding,
// frame geometry, the default oversample ratio and the parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Expected parity bit: even -> XOR of data, odd -> inverted XOR.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 even);
        return (^data) ^ ~even;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Multi-stage synchroniser bringing the asynchronous serial line into the
// clk_i domain. All stages reset to 1 (line idle level) so a reset never
// looks like a start bit.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset
//   d_i    - asynchronous input
//   q_o    - synchronised output
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receive stage: 1 start bit, 8 data bits LSB first,
// optional parity bit, 1 stop bit. The line is sampled using an oversample
// enable (OVERSAMPLE ticks per bit). Each byte is presented with a one-cycle
// valid_o pulse together with parity/framing error flags.
//
// Build option:
//   UART_RX_MAJORITY_EN - when defined, every bit is the 2-of-3 majority of
//                         samples at mid-1, mid and mid+1; all decisions move
//                         one tick later.
//
// Ports:
//   clk_i    - system clock
//   rst_i    - synchronous active-high reset
//   tick_i   - oversample enable, one clk wide
//   rx_i     - asynchronous serial input (idle high)
//   pen_i    - parity enable, latched at start detection
//   peven_i  - 1 = even parity, 0 = odd, latched at start detection
//   dout_o   - received byte
//   valid_o  - one-cycle strobe qualifying dout_o/perr_o/ferr_o
//   perr_o   - parity mismatch
//   ferr_o   - stop bit read as 0
//   busy_o   - frame in progress
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | line idle, waiting for a low level
// ST_START   | timing to mid start bit, rejecting glitches
// ST_DATA    | sampling 8 data bits
// ST_PARITY  | sampling the parity bit
// ST_STOP    | sampling the stop bit, emitting the byte
// ST_WAIT_HIGH | stop bit was low; wait for the line to return high
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 rx_i,
    input  logic                 pen_i,
    input  logic                 peven_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 valid_o,
    output logic                 perr_o,
    output logic                 ferr_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] START_DEC = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] START_DEC = CW'(OVERSAMPLE / 2 - 1);
`endif

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_inc;
    logic [CW-1:0]          dec_cnt;
    logic [2:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   pen_q, peven_q, perr_next_q;
    logic [DATA_BITS-1:0]   dout_q;
    logic                   valid_q, perr_q, ferr_q;
    logic                   rxs;
    logic                   in_frame;
    logic                   bit_tick;
    logic                   bit_val;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    // Last two tick samples; with the current one they form the vote window
    // ending at the decision tick.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '1;
        end else if (tick_i) begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    // The start bit decides at half a bit; after the counter is cleared there,
    // every following decision lands a full bit later at the counter wrap.
    assign dec_cnt  = (state_q == ST_START) ? START_DEC : CNT_LAST;
    assign cnt_inc  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    assign bit_tick = in_frame && tick_i && (cnt_q == dec_cnt);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (!rxs) state_d = ST_START;
            ST_START:     if (bit_tick) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_tick && bit_cnt_q == 3'd7)
                              state_d = pen_q ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (bit_tick) state_d = ST_STOP;
            ST_STOP:      if (bit_tick) state_d = bit_val ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rxs) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_frame = 1'b0;
        case (state_q)
            ST_START, ST_DATA, ST_PARITY, ST_STOP: in_frame = 1'b1;
            default:                               in_frame = 1'b0;
        endcase
        busy_o = in_frame;
    end

    // Datapath: counters, shift register and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pen_q       <= 1'b0;
            peven_q     <= 1'b0;
            perr_next_q <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;

            if (!in_frame) begin
                cnt_q     <= '0;
                bit_cnt_q <= '0;
            end else if (bit_tick && state_q == ST_START) begin
                cnt_q <= '0;
            end else if (tick_i) begin
                cnt_q <= cnt_inc;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        pen_q       <= pen_i;
                        peven_q     <= peven_i;
                        perr_next_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_q   <= {bit_val, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        perr_next_q <= (bit_val != parity_bit(shift_q, peven_q));
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        dout_q  <= shift_q;
                        valid_q <= 1'b1;
                        perr_q  <= perr_next_q;
                        ferr_q  <= ~bit_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;
    assign perr_o  = perr_q;
    assign ferr_o  = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver: OVERSAMPLE=16, tick every 4 clk, so one
// bit lasts 64 clk. A negedge monitor counts valid cycles and records bytes.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       peven = 1'b0;
    logic [7:0] dout;
    logic       valid, perr, ferr, busy;

    int         n_checks = 0;
    int         n_fail = 0;
    int         vcount = 0;
    logic [7:0] last_dout = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;
    logic [7:0] rxq[$];

    uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .tick_i  (tick),
        .rx_i    (rx),
        .pen_i   (pen),
        .peven_i (peven),
        .dout_o  (dout),
        .valid_o (valid),
        .perr_o  (perr),
        .ferr_o  (ferr),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcount    = vcount + 1;
            last_dout = dout;
            last_perr = perr;
            last_ferr = ferr;
            rxq.push_back(dout);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0;
        v0  = vcount;
        pen = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (16) @(negedge clk);
        n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", vcount - v0); end
        n_checks++; if (last_dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h want a5", last_dout); end
        n_checks++; if (last_perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", last_perr); end
        n_checks++; if (last_ferr !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", last_ferr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_parity;
        // byte 0x07 has XOR 1: even wants parity 1, odd wants parity 0
        logic [2:0] pe_t  = 3'b011;   // index 0,1 even; 2 odd
        logic [2:0] pb_t  = 3'b001;   // parity bit sent: 1,0,0
        logic [2:0] exp_t = 3'b010;   // expected perr:   0,1,0
        int v0;
        for (int i = 0; i < 3; i++) begin
            v0    = vcount;
            pen   = 1'b1;
            peven = pe_t[i];
            send_frame(8'h07, 1'b1, pb_t[i], 1'b1);
            repeat (16) @(negedge clk);
            n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL parity_count[%0d]: got %0d want 1", i, vcount - v0); end
            n_checks++; if (last_dout !== 8'h07) begin n_fail++; $display("FAIL parity_dout[%0d]: got %h want 07", i, last_dout); end
            n_checks++; if (last_perr !== exp_t[i]) begin n_fail++; $display("FAIL parity_perr[%0d]: got %b want %b", i, last_perr, exp_t[i]); end
            n_checks++; if (last_ferr !== 1'b0) begin n_fail++; $display("FAIL parity_ferr[%0d]: got %b want 0", i, last_ferr); end
        end
        pen   = 1'b0;
        peven = 1'b0;
    endtask

    task automatic test_false_start;
        int v0;
        v0 = vcount;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
        n_checks++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", vcount - v0); end
    endtask

    task automatic test_break;
        int v0;
        v0 = vcount;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3 * BIT_CLK) @(negedge clk);
        n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", vcount - v0); end
        n_checks++; if (last_dout !== 8'h00) begin n_fail++; $display("FAIL break_dout: got %h want 00", last_dout); end
        n_checks++; if (last_ferr !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b want 1", last_ferr); end
        n_checks++; if (last_perr !== 1'b0) begin n_fail++; $display("FAIL break_perr: got %b want 0", last_perr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %b want 0", busy); end
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL break_recover_count: got %0d want 1", vcount - v0); end
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        repeat (16) @(negedge clk);
        n_checks++; if (vcount - v0 !== 2) begin n_fail++; $display("FAIL break_next_count: got %0d want 2", vcount - v0); end
        n_checks++; if (last_dout !== 8'h96) begin n_fail++; $display("FAIL break_next_dout: got %h want 96", last_dout); end
        n_checks++; if (last_ferr !== 1'b0) begin n_fail++; $display("FAIL break_next_ferr: got %b want 0", last_ferr); end
    endtask

    task automatic test_back_to_back;
        rxq.delete();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        repeat (16) @(negedge clk);
        n_checks++; if (rxq.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", rxq.size()); end
        if (rxq.size() == 2) begin
            n_checks++; if (rxq[0] !== 8'h55) begin n_fail++; $display("FAIL b2b_first: got %h want 55", rxq[0]); end
            n_checks++; if (rxq[1] !== 8'hC3) begin n_fail++; $display("FAIL b2b_second: got %h want c3", rxq[1]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d = 8'h3C;
        int v0;
        v0 = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h want 00", dout); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", valid); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL midrst_perr: got %b want 0", perr); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b want 0", ferr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst = 1'b0;
        rx  = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        n_checks++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL midrst_novalid: got %0d want 0", vcount - v0); end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (16) @(negedge clk);
        n_checks++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d want 1", vcount - v0); end
        n_checks++; if (last_dout !== 8'h3C) begin n_fail++; $display("FAIL midrst_next_dout: got %h want 3c", last_dout); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_break();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
